// File: rtl/ltpi_uart_tx.sv
// ltpi_uart_tx: byte FIFO feeding a UART serialiser (start, LSB-first data,
// optional parity, 1..2 stop bits). Line output is registered and idles high.
module ltpi_uart_tx #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [7:0]  DMASK     = 8'((1 << DATA_BITS) - 1);
    localparam logic [AW:0] FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q, level_d;
    logic          rdy_q;
    logic          push, pop;
    logic [7:0]    head;

    // Serialiser state
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;

    assign push = tx_valid && rdy_q;
    assign head = mem_q[rptr_q] & DMASK;

    // Level follows push/pop; a simultaneous push and pop leaves it unchanged
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO data array; no reset needed, validity is tracked by the level
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= tx_data;
    end

    // FIFO pointers, level and registered ready (low through reset)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
            rdy_q   <= (level_d != FULL);
        end
    end

    // Next-state: bit sequencing on the baud down-counter, pop on IDLE or
    // at the end of the last stop bit so frames run back to back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = (^head) ^ 1'(PARITY_ODD);
                    state_d = S_START;
                    cnt_d   = DIV_M1;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    cnt_d   = DIV_M1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = DIV_M1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PARITY: begin
                if (cnt_q == '0) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    cnt_d   = DIV_M1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = (^head) ^ 1'(PARITY_ODD);
                            state_d = S_START;
                            cnt_d   = DIV_M1;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        cnt_d = DIV_M1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so it changes on the same
    // edge the state does
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // Serialiser registers; reset truncates any frame and returns line high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_ready   = rdy_q;
    assign uart_tx    = tx_q;
    assign busy       = (state_q != S_IDLE) || (level_q != '0);
    assign fifo_level = level_q;

endmodule
